keypad_scanner: RTL

//   Scans a 4x4 active-low matrix keypad, debounces presses and emits a 4-bit hex key code with a one-cycle valid strobe.

---
 rtl/keypad_pkg.sv | 45 ++++
 rtl/sync_2ff.sv | 24 ++
 rtl/keypad_scanner.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared constants for the 4x4 keypad scanner: FSM state encodings, the key map
// and helpers that decode a one-cold column pattern.
package keypad_pkg;

  localparam logic [1:0] SCAN     = 2'd0;
  localparam logic [1:0] DEBOUNCE = 2'd1;
  localparam logic [1:0] HELD     = 2'd2;
  localparam logic [1:0] RELEASE  = 2'd3;

  localparam logic [3:0] KEY_BLANK = 4'hF;
  localparam logic [3:0] COL_IDLE  = 4'b1111;

  // Indexed [row][column]; bottom row is * 0 # D with * and # mapped to E and F.
  localparam logic [3:0] KEY_MAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    return KEY_MAP[r][c];
  endfunction

  function automatic logic single_low(input logic [3:0] v);
    logic hit;
    case (v)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: hit = 1'b1;
      default:                             hit = 1'b0;
    endcase
    return hit;
  endfunction

  function automatic logic [1:0] low_index(input logic [3:0] v);
    logic [1:0] idx;
    case (v)
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Width-parameterised two-flop synchronizer for asynchronous level inputs.
module sync_2ff #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner with debounce and a one-cycle key_valid strobe.
// Define KEYPAD_REPEAT_EN to enable auto-repeat while a key stays held.
import keypad_pkg::*;

module keypad_scanner #(
  parameter int SCAN_DIV     = 16,
  parameter int DEBOUNCE_CYC = 20000
`ifdef KEYPAD_REPEAT_EN
  ,
  parameter int REPEAT_DLY   = 500000,
  parameter int REPEAT_CYC   = 100000
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [3:0] row_n,
  input  logic [3:0] col_n,
  output logic [3:0] hex,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DB_W  = $clog2(DEBOUNCE_CYC);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]  DB_MAX   = DB_W'(DEBOUNCE_CYC - 1);
  // The cycle that moves into DEBOUNCE/RELEASE already counts as stable, so the
  // transition fires one count early to give exactly DEBOUNCE_CYC stable cycles.
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYC - 2);

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DLY > REPEAT_CYC) ? REPEAT_DLY : REPEAT_CYC;
  localparam int REP_W   = $clog2(REP_MAX);
  localparam logic [REP_W-1:0] REP_DLY_LAST = REP_W'(REPEAT_DLY - 1);
  localparam logic [REP_W-1:0] REP_CYC_LAST = REP_W'(REPEAT_CYC - 1);

  logic [REP_W-1:0] rep_cnt;
  logic             rep_armed;
`endif

  logic [1:0]       state;
  logic [1:0]       row_idx;
  logic [1:0]       col_idx;
  logic [3:0]       col_pat;
  logic [3:0]       col_s;
  logic [DIV_W-1:0] div_cnt;
  logic [DB_W-1:0]  db_cnt;

  sync_2ff #(.WIDTH(4), .RESET_VAL(COL_IDLE)) u_col_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (col_n),
    .q     (col_s)
  );

  assign row_n = ~(4'b0001 << row_idx);

  // Scan FSM: the selected row stays driven from detection until the release
  // is debounced, so col_s keeps describing the same key throughout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SCAN;
      row_idx   <= 2'd0;
      col_idx   <= 2'd0;
      col_pat   <= COL_IDLE;
      div_cnt   <= '0;
      db_cnt    <= '0;
      hex       <= KEY_BLANK;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt   <= '0;
      rep_armed <= 1'b0;
`endif
    end else begin
      key_valid <= 1'b0;
      case (state)
        SCAN: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (single_low(col_s)) begin
              col_pat <= col_s;
              col_idx <= low_index(col_s);
              db_cnt  <= '0;
              state   <= DEBOUNCE;
            end else begin
              row_idx <= row_idx + 2'd1;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        DEBOUNCE: begin
          if (col_s != col_pat) begin
            row_idx <= row_idx + 2'd1;
            state   <= SCAN;
          end else if (db_cnt == DB_LAST) begin
            hex       <= key_code(row_idx, col_idx);
            key_valid <= 1'b1;
            key_held  <= 1'b1;
            state     <= HELD;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt   <= '0;
            rep_armed <= 1'b0;
`endif
          end else if (db_cnt != DB_MAX) begin
            db_cnt <= db_cnt + 1'b1;
          end
        end

        HELD: begin
          if (col_s == COL_IDLE) begin
            db_cnt <= '0;
            state  <= RELEASE;
          end
`ifdef KEYPAD_REPEAT_EN
          if (rep_cnt == (rep_armed ? REP_CYC_LAST : REP_DLY_LAST)) begin
            rep_cnt   <= '0;
            rep_armed <= 1'b1;
            key_valid <= 1'b1;
          end else begin
            rep_cnt <= rep_cnt + 1'b1;
          end
`endif
        end

        RELEASE: begin
          if (col_s != COL_IDLE) begin
            state <= HELD;
          end else if (db_cnt == DB_LAST) begin
            key_held <= 1'b0;
            row_idx  <= 2'd0;
            state    <= SCAN;
          end else if (db_cnt != DB_MAX) begin
            db_cnt <= db_cnt + 1'b1;
          end
        end

        default: state <= SCAN;
      endcase
    end
  end

endmodule
